// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA data mover: FSM encoding, transfer direction
// codes and the default per-word address increment.
package adma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_PUSH = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } adma_state_e;

  localparam logic DIR_RAM_TO_FIFO = 1'b1;
  localparam logic DIR_FIFO_TO_RAM = 1'b0;

  localparam int ADDR_STEP_DEFAULT = 4;

endpackage

// File: rtl/adma_addr_counter.sv
// Loadable byte-address / word-count pair. Each step advances the address by
// one word and retires one word; last_o flags the final remaining word.
module adma_addr_counter
  import adma_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_init_i,
  input  logic [CNT_W-1:0]  count_init_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Address arithmetic wraps naturally at 2^ADDR_W.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (load_i) begin
      addr_d  = addr_init_i;
      count_d = count_init_i;
    end else if (step_i) begin
      addr_d  = addr_q + ADDR_W'(ADDR_STEP);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/adma_data_mover.sv
// Word mover between system RAM and the SD data FIFO. RAM->FIFO takes two
// cycles per word (read request, then push); FIFO->RAM moves one word per cycle.
module adma_data_mover
  import adma_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 64,
  parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              start,
  input  logic              direction,
  input  logic [15:0]       length,
  input  logic [ADDR_W-1:0] address_init,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              busy,
  output logic              done
);

  adma_state_e       state_q, state_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              first_q, first_d;
  logic              load_w, step_w, last_w;

  adma_addr_counter #(
    .ADDR_W    (ADDR_W),
    .CNT_W     (16),
    .ADDR_STEP (ADDR_STEP)
  ) u_addr_counter (
    .clk_i        (CLK),
    .rst_ni       (RESET_L),
    .load_i       (load_w),
    .addr_init_i  (address_init),
    .count_init_i (length),
    .step_i       (step_w),
    .addr_o       (ram_addr),
    .last_o       (last_w)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    hold_d    = hold_q;
    first_d   = 1'b0;
    load_w    = 1'b0;
    step_w    = 1'b0;
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_w = 1'b1;
          dir_d  = direction;
          if (length == 16'd0)                    state_d = ST_DONE;
          else if (direction == DIR_RAM_TO_FIFO)  state_d = ST_RD_REQ;
          else                                    state_d = ST_WR;
        end
      end

      ST_RD_REQ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!fifo_full) begin
          ram_rd_en = 1'b1;
          first_d   = 1'b1;
          state_d   = ST_RD_PUSH;
        end
      end

      // RAM data is only valid on the entry cycle, so it is parked in hold_q
      // in case the FIFO stalls the push.
      ST_RD_PUSH: begin
        if (first_q) hold_d = ram_rd_data;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!fifo_full) begin
          fifo_push = 1'b1;
          step_w    = 1'b1;
          if (last_w)                         state_d = ST_DONE;
          else if (dir_q == DIR_RAM_TO_FIFO)  state_d = ST_RD_REQ;
          else                                state_d = ST_WR;
        end
      end

      ST_WR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          ram_wr_en = 1'b1;
          step_w    = 1'b1;
          if (last_w)                         state_d = ST_DONE;
          else if (dir_q == DIR_FIFO_TO_RAM)  state_d = ST_WR;
          else                                state_d = ST_RD_REQ;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_FIFO_TO_RAM;
      hold_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      first_q <= first_d;
    end
  end

  assign fifo_wr_data = first_q ? ram_rd_data : hold_q;
  assign ram_wr_data  = fifo_rd_data;
  assign busy         = (state_q != ST_IDLE);

endmodule
